m_prefetch_queue: RTL and testbench

Instruction prefetch stage between a synchronous, one-cycle-latency instruction memory and the decode stage of the pipelined core. It keeps a fetch PC and issues one word request per cycle while space remains. Returned words are buffered with their PCs in a small FIFO, and decode pops them through a valid/ready handshake. A branch-miss redirect flushes the queue, squashes any in-flight response, and restarts fetch at the target.

---
 rtl/m_prefetch_queue.sv | 108 ++++++++++
 tb/tb_m_prefetch_queue.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/m_prefetch_queue.sv
// Instruction prefetch queue: one-word-per-cycle fetch from a 1-cycle imem into a FIFO popped by decode.
// Optional PREFETCH_BYPASS_EN forwards an arriving word straight to decode when the queue is empty.
module m_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        w_clock,
    input  logic        w_reset,
    input  logic        w_redirect,
    input  logic [31:0] w_redirect_pc,
    output logic        w_imem_req,
    output logic [31:0] w_imem_addr,
    input  logic [31:0] w_imem_data,
    input  logic        w_ready,
    output logic        w_valid,
    output logic [31:0] w_ir,
    output logic [31:0] w_pc
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_OCC = (CW + 1)'(DEPTH);
    localparam logic [31:0]   NOP       = 32'h0000_0013;

    logic [31:0]   r_fpc;
    logic          r_pend;
    logic [31:0]   r_pend_pc;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_mem_ir [DEPTH];
    logic [31:0]   r_mem_pc [DEPTH];

    logic          resp;
    logic          empty;
    logic          push;
    logic          pop;
    logic [CW:0]   occ;

    // Occupancy counts the in-flight word so a full queue never receives a push.
    assign occ         = {1'b0, r_count} + {{CW{1'b0}}, r_pend};
    assign w_imem_req  = !w_reset && !w_redirect && (occ < DEPTH_OCC);
    assign w_imem_addr = r_fpc;
    assign resp        = r_pend && !w_redirect && !w_reset;
    assign empty       = (r_count == '0);

`ifdef PREFETCH_BYPASS_EN
    logic byp;

    assign byp     = empty && resp;
    assign w_valid = (!empty || byp) && !w_redirect && !w_reset;
    assign w_ir    = !w_valid ? NOP   : (byp ? w_imem_data : r_mem_ir[r_rptr]);
    assign w_pc    = !w_valid ? 32'h0 : (byp ? r_pend_pc   : r_mem_pc[r_rptr]);
    assign push    = resp && !(byp && w_ready);
    assign pop     = w_valid && w_ready && !empty;
`else
    assign w_valid = !empty && !w_redirect && !w_reset;
    assign w_ir    = w_valid ? r_mem_ir[r_rptr] : NOP;
    assign w_pc    = w_valid ? r_mem_pc[r_rptr] : 32'h0;
    assign push    = resp;
    assign pop     = w_valid && w_ready;
`endif

    always_ff @(posedge w_clock) begin
        if (w_reset) begin
            r_fpc     <= RESET_PC;
            r_pend    <= 1'b0;
            r_pend_pc <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
        end else if (w_redirect) begin
            r_fpc   <= w_redirect_pc & 32'hFFFF_FFFC;
            r_pend  <= 1'b0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_pend <= w_imem_req;
            if (w_imem_req) begin
                r_fpc     <= r_fpc + 32'd4;
                r_pend_pc <= r_fpc;
            end
            if (push)
                r_wptr <= r_wptr + AW'(1);
            if (pop)
                r_rptr <= r_rptr + AW'(1);
            if (push && !pop)
                r_count <= r_count + CW'(1);
            else if (pop && !push)
                r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge w_clock) begin
        if (push) begin
            r_mem_ir[r_wptr] <= w_imem_data;
            r_mem_pc[r_wptr] <= r_pend_pc;
        end
    end

    always_ff @(posedge w_clock) begin
        if (!w_reset)
            assert (!(push && r_count == DEPTH_C));
    end

endmodule

// File: tb/tb_m_prefetch_queue.sv
// Self-checking bench for m_prefetch_queue: vector table for the streaming case plus
// hand-written backpressure, redirect, reset and toggling-ready sequences.
module tb_m_prefetch_queue;

    localparam int DEPTH = 4;
`ifdef PREFETCH_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif
    localparam int LAT = 2 - BYP;

    logic        w_clock = 1'b0;
    logic        w_reset = 1'b1;
    logic        w_redirect = 1'b0;
    logic [31:0] w_redirect_pc = '0;
    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic [31:0] w_imem_data = '0;
    logic        w_ready = 1'b0;
    logic        w_valid;
    logic [31:0] w_ir;
    logic [31:0] w_pc;

    int n_pass  = 0;
    int n_total = 0;

    m_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .w_clock       (w_clock),
        .w_reset       (w_reset),
        .w_redirect    (w_redirect),
        .w_redirect_pc (w_redirect_pc),
        .w_imem_req    (w_imem_req),
        .w_imem_addr   (w_imem_addr),
        .w_imem_data   (w_imem_data),
        .w_ready       (w_ready),
        .w_valid       (w_valid),
        .w_ir          (w_ir),
        .w_pc          (w_pc)
    );

    always #5 w_clock = ~w_clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   mem_word = 32'h00100093;
            32'h4:   mem_word = 32'h00200113;
            32'h8:   mem_word = 32'h002081b3;
            32'hC:   mem_word = 32'h00000013;
            default: mem_word = {16'hC0DE, a[15:0]};
        endcase
    endfunction

    // One-cycle-latency instruction memory.
    always @(posedge w_clock) w_imem_data <= mem_word(w_imem_addr);

    task automatic applyStimulus(input logic rst, input logic rdr, input logic [31:0] rpc, input logic rdy);
        @(negedge w_clock);
        w_reset       = rst;
        w_redirect    = rdr;
        w_redirect_pc = rpc;
        w_ready       = rdy;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    endtask

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_ir;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int n_req;
        int n_emit;
        int first_cyc;
        int max_count;
        logic [31:0] exp_pc;

        // Row 0 is a reset cycle; rows 1..8 are cycles 0..7 with decode always ready.
        vecs[0] = '{rst: 1'b1, rdy: 1'b1, exp_req: 1'b0, exp_addr: 32'h0,
                    exp_valid: 1'b0, exp_ir: 32'h13, exp_pc: 32'h0};
        for (int k = 0; k < 8; k++) begin
            vecs[k+1].rst       = 1'b0;
            vecs[k+1].rdy       = 1'b1;
            vecs[k+1].exp_req   = 1'b1;
            vecs[k+1].exp_addr  = 32'(4 * k);
            vecs[k+1].exp_valid = (k >= LAT);
            vecs[k+1].exp_pc    = (k >= LAT) ? 32'(4 * (k - LAT)) : 32'h0;
            vecs[k+1].exp_ir    = (k >= LAT) ? mem_word(32'(4 * (k - LAT))) : 32'h13;
        end

        $display("[TB] streaming vectors");
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].rst, 1'b0, 32'h0, vecs[i].rdy);
            checkOutput($sformatf("vec%0d_req", i),   w_imem_req,  vecs[i].exp_req);
            checkOutput($sformatf("vec%0d_addr", i),  w_imem_addr, vecs[i].exp_addr);
            checkOutput($sformatf("vec%0d_valid", i), w_valid,     vecs[i].exp_valid);
            checkOutput($sformatf("vec%0d_ir", i),    w_ir,        vecs[i].exp_ir);
            checkOutput($sformatf("vec%0d_pc", i),    w_pc,        vecs[i].exp_pc);
        end

        $display("[TB] backpressure from reset");
        doReset();
        n_req = 0;
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
            if (c >= 4)
                checkOutput($sformatf("bp_req_stopped_c%0d", c), w_imem_req, 1'b0);
            n_req += int'(w_imem_req);
        end
        checkOutput("bp_req_total", n_req, DEPTH);
        checkOutput("bp_count_full", dut.r_count, DEPTH);
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
            checkOutput($sformatf("bp_drain_valid%0d", c), w_valid, 1'b1);
            checkOutput($sformatf("bp_drain_pc%0d", c), w_pc, 32'(4 * c));
            checkOutput($sformatf("bp_drain_ir%0d", c), w_ir, mem_word(32'(4 * c)));
        end

        $display("[TB] redirect with queued entries");
        doReset();
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, c == 2);
            if (c == 2) begin
                checkOutput("rd_pre_valid", w_valid, 1'b1);
                checkOutput("rd_pre_pc", w_pc, 32'h0);
            end
        end
        applyStimulus(1'b0, 1'b1, 32'h40, 1'b0);
        checkOutput("rd_pre_count", dut.r_count, 3);
        checkOutput("rd_pre_pend", dut.r_pend, 1'b1);
        checkOutput("rd_valid_low", w_valid, 1'b0);
        checkOutput("rd_req_low", w_imem_req, 1'b0);
        checkOutput("rd_ir_nop", w_ir, 32'h13);
        n_emit = 0;
        first_cyc = -1;
        for (int c = 6; c < 16; c++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
            if (c == 6) begin
                checkOutput("rd_addr_target", w_imem_addr, 32'h40);
                checkOutput("rd_req_target", w_imem_req, 1'b1);
            end
            if (w_valid) begin
                if (n_emit == 0) begin
                    first_cyc = c;
                    checkOutput("rd_first_pc", w_pc, 32'h40);
                    checkOutput("rd_first_cycle", first_cyc, 8 - BYP);
                end else if (n_emit == 1) begin
                    checkOutput("rd_second_pc", w_pc, 32'h44);
                end
                n_emit++;
            end
        end
        checkOutput("rd_emitted", n_emit >= 2, 1'b1);

        $display("[TB] redirect to unaligned target");
        applyStimulus(1'b0, 1'b1, 32'h43, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("ua_addr", w_imem_addr, 32'h40);
        n_emit = 0;
        for (int c = 0; c < 6 && n_emit == 0; c++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
            if (w_valid) begin
                checkOutput("ua_first_pc", w_pc, 32'h40);
                checkOutput("ua_first_ir", w_ir, mem_word(32'h40));
                n_emit++;
            end
        end
        checkOutput("ua_emitted", n_emit, 1);

        $display("[TB] reset mid-stream");
        doReset();
        for (int c = 0; c < 3; c++)
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("mr_pre_count", dut.r_count, 2);
        checkOutput("mr_valid", w_valid, 1'b0);
        checkOutput("mr_ir", w_ir, 32'h13);
        checkOutput("mr_pc", w_pc, 32'h0);
        checkOutput("mr_req", w_imem_req, 1'b0);
        first_cyc = -1;
        for (int c = 0; c < 8 && first_cyc < 0; c++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
            if (c == 0) begin
                checkOutput("mr_restart_addr", w_imem_addr, 32'h0);
                checkOutput("mr_restart_req", w_imem_req, 1'b1);
            end
            if (w_valid) begin
                first_cyc = c;
                checkOutput("mr_first_pc", w_pc, 32'h0);
                checkOutput("mr_first_ir", w_ir, 32'h00100093);
            end
        end
        checkOutput("mr_first_cycle", first_cyc, LAT);

        $display("[TB] toggling ready");
        doReset();
        exp_pc = 32'h0;
        n_emit = 0;
        max_count = 0;
        for (int c = 0; c < 200; c++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, c[0]);
            if (int'(dut.r_count) > max_count)
                max_count = int'(dut.r_count);
            if (w_valid && w_ready) begin
                checkOutput($sformatf("tg_pc%0d", n_emit), w_pc, exp_pc);
                exp_pc += 32'd4;
                n_emit++;
            end
        end
        checkOutput("tg_max_count", max_count <= DEPTH, 1'b1);
        checkOutput("tg_progress", n_emit >= 90, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
